sensor_tx_arbiter: RTL

Shares the 40-bit UART TX word channel between two sensor sources: ADS1292 72-bit continuous-read samples and MPR121 12-bit touch-status updates. Each source is captured into a one-entry pending buffer. Captured data is framed into 40-bit words of the form {header byte, 32-bit payload} and sent over a valid/ready handshake to the UART controller. The block sits in sensor_core, between the sensor controller host sides and the UART TX interface.

---
 rtl/sensor_tx_pkg.sv | 31 +++
 rtl/sensor_tx_pend_buf.sv | 61 ++++++
 rtl/sensor_tx_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sensor_tx_pkg.sv
// ---------------------------------------------------------------------------
// sensor_tx_pkg
// Shared definitions for the sensor TX arbiter: UART word width, frame
// header bytes and the arbiter FSM state encoding.
//
// Optional feature macro: SENSOR_TX_CHECKSUM_EN adds the ADSCK state and its
// header, used for the trailing checksum word of an ADS frame.
// ---------------------------------------------------------------------------
package sensor_tx_pkg;

    localparam int UART_W = 40;

    localparam logic [7:0] HDR_ADS0 = 8'hA1;
    localparam logic [7:0] HDR_ADS1 = 8'hA2;
    localparam logic [7:0] HDR_ADS2 = 8'hA3;
    localparam logic [7:0] HDR_ADSCK = 8'hAC;
    localparam logic [7:0] HDR_TCH  = 8'hB1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADS0  = 3'd1,
        ST_ADS1  = 3'd2,
        ST_ADS2  = 3'd3,
        ST_TCH   = 3'd4
`ifdef SENSOR_TX_CHECKSUM_EN
        ,
        ST_ADSCK = 3'd5
`endif
    } state_e;

endpackage

// File: rtl/sensor_tx_pend_buf.sv
// ---------------------------------------------------------------------------
// sensor_tx_pend_buf
// One-entry pending buffer between a sensor pulse interface and the TX
// arbiter. In drop mode (OVERWRITE=0) a capture into a full buffer that is
// not being drained is rejected and flagged on drop_o; in overwrite mode the
// newest value replaces the stored one.
//
// Ports:
//   clk      in   system clock
//   rstn     in   synchronous active-low reset (clears the full flag only)
//   cap_i    in   capture request (already qualified with enable)
//   data_i   in   value to capture
//   drain_i  in   arbiter copies the buffer out this cycle
//   full_o   out  buffer holds an unsent value
//   data_o   out  stored value
//   drop_o   out  one-cycle pulse: capture rejected (drop mode only)
// ---------------------------------------------------------------------------
module sensor_tx_pend_buf #(
    parameter int W         = 8,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cap_i,
    input  logic [W-1:0] data_i,
    input  logic         drain_i,
    output logic         full_o,
    output logic [W-1:0] data_o,
    output logic         drop_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q;
    logic         accept;

    // A capture coinciding with a drain is accepted: the old value leaves
    // through the drain while the new one takes its slot.
    always_comb begin
        accept = cap_i && (!full_q || drain_i || OVERWRITE);
        drop_o = cap_i && full_q && !drain_i && !OVERWRITE;
        full_d = full_q;
        if (drain_i) full_d = 1'b0;
        if (accept)  full_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) data_q <= data_i;
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/sensor_tx_arbiter.sv
// ---------------------------------------------------------------------------
// sensor_tx_arbiter
// Shares the 40-bit UART TX word channel between ADS1292 samples (72 bit,
// sent as three words) and MPR121 touch status (12 bit, one word). Each
// source owns a one-entry pending buffer; an FSM arbitrates in IDLE, copies
// the granted buffer into a frame register and streams the frame words over
// a valid/ready handshake. ADS is preferred, but after STARVE_LIMIT
// consecutive ADS grants with touch waiting, touch wins the next arbitration.
//
// Optional feature macro: SENSOR_TX_CHECKSUM_EN appends a fourth ADS word
// (hdr 0xAC) carrying the modulo-256 byte sum of the 72-bit sample.
//
// Ports:
//   clk           in   system clock
//   rstn          in   synchronous active-low reset
//   enable        in   capture enable; pending data still drains when low
//   ads_data      in   ADS sample, valid with ads_valid
//   ads_valid     in   one-cycle pulse: new ADS sample
//   touch_data    in   touch status, valid with touch_valid
//   touch_valid   in   one-cycle pulse: new touch status
//   uart_data     out  TX word {hdr[7:0], payload[31:0]}, zero when idle
//   uart_valid    out  TX word valid
//   uart_ready    in   UART accepts the word
//   ads_drop_cnt  out  saturating count of rejected ADS samples
//   busy          out  FSM active or any pending buffer full
// ---------------------------------------------------------------------------
module sensor_tx_arbiter
    import sensor_tx_pkg::*;
#(
    parameter int ADS_W        = 72,
    parameter int TOUCH_W      = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [ADS_W-1:0]   ads_data,
    input  logic               ads_valid,
    input  logic [TOUCH_W-1:0] touch_data,
    input  logic               touch_valid,
    output logic [UART_W-1:0]  uart_data,
    output logic               uart_valid,
    input  logic               uart_ready,
    output logic [15:0]        ads_drop_cnt,
    output logic               busy
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef SENSOR_TX_CHECKSUM_EN
    function automatic logic [7:0] byte_sum(input logic [ADS_W-1:0] d);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < ADS_W / 8; i++) begin
            s = s + d[i*8 +: 8];
        end
        return s;
    endfunction
`endif

    state_e               state_q, state_d;
    logic [ADS_W-1:0]     ads_frm_q;
    logic [TOUCH_W-1:0]   tch_frm_q;
    logic [7:0]           seq_a_q, seq_t_q;
    logic [STARVE_W-1:0]  starve_q;
    logic [15:0]          drop_cnt_q;

    logic                 ads_full, tch_full, ads_drop, tch_drop_unused;
    logic [ADS_W-1:0]     ads_pend;
    logic [TOUCH_W-1:0]   tch_pend;
    logic                 grant_ads, grant_tch;
    logic                 last_ads, last_tch;
    logic                 xfer;

    sensor_tx_pend_buf #(.W(ADS_W), .OVERWRITE(1'b0)) u_ads_buf (
        .clk     (clk),
        .rstn    (rstn),
        .cap_i   (ads_valid && enable),
        .data_i  (ads_data),
        .drain_i (grant_ads),
        .full_o  (ads_full),
        .data_o  (ads_pend),
        .drop_o  (ads_drop)
    );

    sensor_tx_pend_buf #(.W(TOUCH_W), .OVERWRITE(1'b1)) u_tch_buf (
        .clk     (clk),
        .rstn    (rstn),
        .cap_i   (touch_valid && enable),
        .data_i  (touch_data),
        .drain_i (grant_tch),
        .full_o  (tch_full),
        .data_o  (tch_pend),
        .drop_o  (tch_drop_unused)
    );

    assign uart_valid = (state_q != ST_IDLE);
    assign xfer       = uart_valid && uart_ready;

    // Arbitration only happens in IDLE; grants double as buffer drains.
    always_comb begin
        grant_ads = 1'b0;
        grant_tch = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ads_full && (!tch_full || starve_q < STARVE_MAX)) begin
                grant_ads = 1'b1;
            end else if (tch_full) begin
                grant_tch = 1'b1;
            end
        end
    end

    // Next state and word mux. uart_data is a pure function of the state and
    // frame registers, so it cannot change while a word waits for ready.
    always_comb begin
        state_d   = state_q;
        last_ads  = 1'b0;
        last_tch  = 1'b0;
        uart_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_ads)      state_d = ST_ADS0;
                else if (grant_tch) state_d = ST_TCH;
            end
            ST_ADS0: begin
                uart_data = {HDR_ADS0, seq_a_q, ads_frm_q[ADS_W-1 -: 24]};
                if (xfer) state_d = ST_ADS1;
            end
            ST_ADS1: begin
                uart_data = {HDR_ADS1, 8'h00, ads_frm_q[ADS_W-25 -: 24]};
                if (xfer) state_d = ST_ADS2;
            end
            ST_ADS2: begin
                uart_data = {HDR_ADS2, 8'h00, ads_frm_q[23:0]};
                if (xfer) begin
`ifdef SENSOR_TX_CHECKSUM_EN
                    state_d = ST_ADSCK;
`else
                    state_d  = ST_IDLE;
                    last_ads = 1'b1;
`endif
                end
            end
`ifdef SENSOR_TX_CHECKSUM_EN
            ST_ADSCK: begin
                uart_data = {HDR_ADSCK, 24'h000000, byte_sum(ads_frm_q)};
                if (xfer) begin
                    state_d  = ST_IDLE;
                    last_ads = 1'b1;
                end
            end
`endif
            ST_TCH: begin
                uart_data = {HDR_TCH, seq_t_q, {(24-TOUCH_W){1'b0}}, tch_frm_q};
                if (xfer) begin
                    state_d  = ST_IDLE;
                    last_tch = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            seq_a_q    <= 8'h00;
            seq_t_q    <= 8'h00;
            starve_q   <= '0;
            drop_cnt_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (last_ads) seq_a_q <= seq_a_q + 8'd1;
            if (last_tch) seq_t_q <= seq_t_q + 8'd1;
            // Counts ADS wins that pushed a waiting touch frame back.
            if (grant_ads && tch_full) begin
                starve_q <= starve_q + STARVE_W'(1);
            end else if (grant_tch) begin
                starve_q <= '0;
            end
            if (ads_drop) drop_cnt_q <= sat_inc16(drop_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (grant_ads) ads_frm_q <= ads_pend;
        if (grant_tch) tch_frm_q <= tch_pend;
    end

    assign ads_drop_cnt = drop_cnt_q;
    assign busy         = (state_q != ST_IDLE) || ads_full || tch_full;

endmodule
